// File: rtl/ram_pkg.sv
// Shared types and helpers for the ping-pong frame RAM.
package ram_pkg;

  // One bit selects between the two frame banks.
  typedef logic bank_t;

  localparam int unsigned RdLatMin = 1;
  localparam int unsigned RdLatMax = 2;

  // Only a bare registered read or one extra output register are supported.
  function automatic bit rd_lat_legal(input int unsigned lat);
    return (lat >= RdLatMin) && (lat <= RdLatMax);
  endfunction

  // Number of words addressed by an addr_w-bit address.
  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_pingpong_if.sv
// Producer/consumer bus of the ping-pong frame RAM.
interface ram_pingpong_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 7
);
  import ram_pkg::*;

  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              wr_done;
  logic              wr_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic              rd_done;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  bank_t             wr_bank;
  bank_t             rd_bank;
  logic              overflow;
  logic              underrun;

  // Writer/reader side.
  modport master (
    output wr_data, wr_addr, wr_en, wr_done, rd_addr, rd_en, rd_done,
    input  wr_ready, rd_ready, rd_data, rd_valid, wr_bank, rd_bank, overflow, underrun
  );

  // RAM side.
  modport slave (
    input  wr_data, wr_addr, wr_en, wr_done, rd_addr, rd_en, rd_done,
    output wr_ready, rd_ready, rd_data, rd_valid, wr_bank, rd_bank, overflow, underrun
  );

endinterface

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port, no array reset.
module ram_sdp
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              i_clock,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int unsigned Depth = depth_of(ADDR_W);

  logic [DATA_W-1:0] r_mem [Depth];
  logic [DATA_W-1:0] r_q;

  // Write port and registered read port; the read register holds between reads.
  always_ff @(posedge i_clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_q <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_q;

endmodule

// File: rtl/ram_pingpong.sv
// Double-buffered frame RAM: writer fills one bank while the reader scans the other.
module ram_pingpong
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned HOLD_LAST = 1
) (
  input logic           clock,
  input logic           nrst,
  ram_pingpong_if.slave bus
);

  bank_t             r_wr_bank, r_rd_bank, w_wr_bank_nxt, w_rd_bank_nxt;
  logic [1:0]        r_full, w_full_nxt;
  logic              r_overflow, r_underrun, w_overflow_nxt, w_underrun_nxt;
  logic              r_rd_vld;
  logic              w_wr_ready, w_rd_ready, w_wr_acc, w_rd_acc, w_rd_swap;
  logic [DATA_W-1:0] w_ram_q;

  assign w_wr_ready = ~r_full[r_wr_bank];
  assign w_rd_ready = r_full[r_rd_bank];
  assign w_wr_acc   = nrst & bus.wr_en & w_wr_ready;
  assign w_rd_acc   = nrst & bus.rd_en & w_rd_ready;
  // With hold-last the reader keeps its frame unless the other bank was already full pre-edge.
  assign w_rd_swap  = bus.rd_done & w_rd_ready & ((HOLD_LAST == 0) | r_full[~r_rd_bank]);

  // Next bank flags, pointers and sticky error flags from pre-edge state.
  always_comb begin
    w_full_nxt     = r_full;
    w_wr_bank_nxt  = r_wr_bank;
    w_rd_bank_nxt  = r_rd_bank;
    w_overflow_nxt = r_overflow | ((bus.wr_en | bus.wr_done) & ~w_wr_ready);
    w_underrun_nxt = r_underrun | ((bus.rd_en | bus.rd_done) & ~w_rd_ready);
    if (bus.wr_done && w_wr_ready) begin
      w_full_nxt[r_wr_bank] = 1'b1;
      w_wr_bank_nxt         = ~r_wr_bank;
    end
    if (w_rd_swap) begin
      w_full_nxt[r_rd_bank] = 1'b0;
      w_rd_bank_nxt         = ~r_rd_bank;
    end
  end

  // Control state and first read-valid stage.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      r_full     <= 2'b00;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_overflow <= 1'b0;
      r_underrun <= 1'b0;
      r_rd_vld   <= 1'b0;
    end else begin
      r_full     <= w_full_nxt;
      r_wr_bank  <= w_wr_bank_nxt;
      r_rd_bank  <= w_rd_bank_nxt;
      r_overflow <= w_overflow_nxt;
      r_underrun <= w_underrun_nxt;
      r_rd_vld   <= w_rd_acc;
    end
  end

  ram_sdp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W + 1)
  ) u_ram (
    .i_clock   (clock),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr ({r_wr_bank, bus.wr_addr}),
    .i_wr_data (bus.wr_data),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr ({r_rd_bank, bus.rd_addr}),
    .o_rd_data (w_ram_q)
  );

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("ram_pingpong: RD_LAT must be 1 or 2");
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              r_vld2;
    logic [DATA_W-1:0] r_dout;

    // Extra output register; idle cycles present zero data.
    always_ff @(posedge clock) begin
      if (!nrst) begin
        r_vld2 <= 1'b0;
        r_dout <= '0;
      end else begin
        r_vld2 <= r_rd_vld;
        r_dout <= r_rd_vld ? w_ram_q : '0;
      end
    end

    assign bus.rd_valid = r_vld2;
    assign bus.rd_data  = r_dout;
  end else begin : g_lat1
    // The array register has no reset, so mask it until a read is valid.
    assign bus.rd_valid = r_rd_vld;
    assign bus.rd_data  = r_rd_vld ? w_ram_q : '0;
  end

  assign bus.wr_ready = w_wr_ready;
  assign bus.rd_ready = w_rd_ready;
  assign bus.wr_bank  = r_wr_bank;
  assign bus.rd_bank  = r_rd_bank;
  assign bus.overflow = r_overflow;
  assign bus.underrun = r_underrun;

endmodule

// File: tb/tb_ram_pingpong.sv
// Bench for ram_pingpong: three configurations share one stimulus stream and are
// compared every cycle against a frame-level reference model.
module tb_ram_pingpong;
  import ram_pkg::*;

  localparam int unsigned DW   = 24;
  localparam int unsigned AW   = 7;
  localparam int unsigned ND   = 3;
  localparam int unsigned BDEP = 128;
  localparam int unsigned LAT  [ND] = '{1, 1, 2};
  localparam int unsigned HOLD [ND] = '{1, 0, 1};

  typedef struct packed {
    logic          wr_en;
    logic          wr_done;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic          rd_done;
    logic [AW-1:0] rd_addr;
  } stim_t;

  typedef struct packed {
    logic          wr_ready;
    logic          rd_ready;
    logic          rd_valid;
    logic          wr_bank;
    logic          rd_bank;
    logic          overflow;
    logic          underrun;
    logic [DW-1:0] rd_data;
  } obs_t;

  logic  clock = 1'b0;
  logic  nrst  = 1'b0;
  stim_t s;
  obs_t  obs [ND];

  always #5 clock = ~clock;

  ram_pingpong_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  ram_pingpong_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  ram_pingpong_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

  assign {bus0.wr_en, bus0.wr_done, bus0.wr_addr, bus0.wr_data,
          bus0.rd_en, bus0.rd_done, bus0.rd_addr} = s;
  assign {bus1.wr_en, bus1.wr_done, bus1.wr_addr, bus1.wr_data,
          bus1.rd_en, bus1.rd_done, bus1.rd_addr} = s;
  assign {bus2.wr_en, bus2.wr_done, bus2.wr_addr, bus2.wr_data,
          bus2.rd_en, bus2.rd_done, bus2.rd_addr} = s;

  assign obs[0] = {bus0.wr_ready, bus0.rd_ready, bus0.rd_valid, bus0.wr_bank, bus0.rd_bank,
                   bus0.overflow, bus0.underrun, bus0.rd_data};
  assign obs[1] = {bus1.wr_ready, bus1.rd_ready, bus1.rd_valid, bus1.wr_bank, bus1.rd_bank,
                   bus1.overflow, bus1.underrun, bus1.rd_data};
  assign obs[2] = {bus2.wr_ready, bus2.rd_ready, bus2.rd_valid, bus2.wr_bank, bus2.rd_bank,
                   bus2.overflow, bus2.underrun, bus2.rd_data};

  ram_pingpong #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .HOLD_LAST(1)) dut0 (
    .clock (clock), .nrst (nrst), .bus (bus0)
  );
  ram_pingpong #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .HOLD_LAST(0)) dut1 (
    .clock (clock), .nrst (nrst), .bus (bus1)
  );
  ram_pingpong #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .HOLD_LAST(1)) dut2 (
    .clock (clock), .nrst (nrst), .bus (bus2)
  );

  // Reference model: per-configuration memory image, frame flags and a read delay line.
  logic [DW-1:0] m_mem   [ND][2*BDEP];
  bit            m_known [ND][2*BDEP];
  bit            m_full  [ND][2];
  bit            m_wb [ND], m_rb [ND], m_ovf [ND], m_und [ND];
  bit            m_pv [ND][2], m_pk [ND][2];
  logic [DW-1:0] m_pd [ND][2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < ND; i++) begin
      bit            wrdy, rrdy, other, nv, nk;
      int            ridx, widx;
      logic [DW-1:0] nd;
      if (!nrst) begin
        m_full[i] = '{0, 0};
        m_wb[i]   = 0;
        m_rb[i]   = 0;
        m_ovf[i]  = 0;
        m_und[i]  = 0;
        m_pv[i]   = '{0, 0};
        m_pk[i]   = '{0, 0};
        continue;
      end
      wrdy  = !m_full[i][m_wb[i]];
      rrdy  = m_full[i][m_rb[i]];
      other = m_full[i][!m_rb[i]];
      ridx  = int'(m_rb[i]) * BDEP + int'(s.rd_addr);
      widx  = int'(m_wb[i]) * BDEP + int'(s.wr_addr);
      nv    = s.rd_en && rrdy;
      nd    = nv ? m_mem[i][ridx] : '0;
      nk    = nv && m_known[i][ridx];
      m_pv[i][1] = m_pv[i][0];
      m_pk[i][1] = m_pk[i][0];
      m_pd[i][1] = m_pd[i][0];
      m_pv[i][0] = nv;
      m_pk[i][0] = nk;
      m_pd[i][0] = nd;
      if ((s.rd_en || s.rd_done) && !rrdy) m_und[i] = 1;
      if ((s.wr_en || s.wr_done) && !wrdy) m_ovf[i] = 1;
      if (s.wr_en && wrdy) begin
        m_mem[i][widx]   = s.wr_data;
        m_known[i][widx] = 1;
      end
      if (s.wr_done && wrdy) begin
        m_full[i][m_wb[i]] = 1;
        m_wb[i]            = !m_wb[i];
      end
      if (s.rd_done && rrdy && (HOLD[i] == 0 || other)) begin
        m_full[i][m_rb[i]] = 0;
        m_rb[i]            = !m_rb[i];
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < ND; i++) begin
      int k;
      k = (LAT[i] == 1) ? 0 : 1;
      check($sformatf("d%0d.wr_ready", i), 32'(obs[i].wr_ready), 32'(!m_full[i][m_wb[i]]));
      check($sformatf("d%0d.rd_ready", i), 32'(obs[i].rd_ready), 32'(m_full[i][m_rb[i]]));
      check($sformatf("d%0d.wr_bank", i), 32'(obs[i].wr_bank), 32'(m_wb[i]));
      check($sformatf("d%0d.rd_bank", i), 32'(obs[i].rd_bank), 32'(m_rb[i]));
      check($sformatf("d%0d.overflow", i), 32'(obs[i].overflow), 32'(m_ovf[i]));
      check($sformatf("d%0d.underrun", i), 32'(obs[i].underrun), 32'(m_und[i]));
      check($sformatf("d%0d.rd_valid", i), 32'(obs[i].rd_valid), 32'(m_pv[i][k]));
      if (m_pv[i][k] && m_pk[i][k])
        check($sformatf("d%0d.rd_data", i), 32'(obs[i].rd_data), 32'(m_pd[i][k]));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    s    = '0;
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
  endtask

  task automatic write_words(input int n, input logic [DW-1:0] mult, input bit done);
    for (int a = 0; a < n; a++) begin
      s         = '0;
      s.wr_en   = 1'b1;
      s.wr_addr = AW'(a);
      s.wr_data = DW'(a) * mult;
      tick();
    end
    s = '0;
    if (done) begin
      s.wr_done = 1'b1;
      tick();
      s = '0;
    end
  endtask

  task automatic read_burst(input int start, input int n);
    for (int k = 0; k < n; k++) begin
      s         = '0;
      s.rd_en   = 1'b1;
      s.rd_addr = AW'(start + k);
      tick();
    end
    s = '0;
    tick();
    tick();
  endtask

  initial begin
    int            cnt, first;
    logic [DW-1:0] first_data;
    s = '0;
    tick();
    tick();
    for (int i = 0; i < ND; i++) check($sformatf("rst.rd_data%0d", i), 32'(obs[i].rd_data), 0);
    nrst = 1'b1;

    // Fill bank 0 with addr*0x010101 and read it back.
    write_words(BDEP, 24'h010101, 1'b1);
    for (int i = 0; i < ND; i++) begin
      check($sformatf("fill.rd_ready%0d", i), 32'(obs[i].rd_ready), 1);
      check($sformatf("fill.wr_bank%0d", i), 32'(obs[i].wr_bank), 1);
    end
    read_burst(0, BDEP);

    // Frame done with no new frame: hold-last re-reads, otherwise underrun.
    s.rd_done = 1'b1;
    tick();
    s = '0;
    check("hold.rd_bank0", 32'(obs[0].rd_bank), 0);
    check("nohold.rd_ready1", 32'(obs[1].rd_ready), 0);
    read_burst(0, 8);
    check("hold.underrun0", 32'(obs[0].underrun), 0);
    check("nohold.underrun1", 32'(obs[1].underrun), 1);

    // Simultaneous wr_done and rd_done.
    do_reset();
    write_words(BDEP, 24'h00a5a5, 1'b1);
    write_words(16, 24'h000301, 1'b0);
    read_burst(0, 4);
    s.wr_done = 1'b1;
    s.rd_done = 1'b1;
    tick();
    s = '0;
    check("sim.rd_bank1", 32'(obs[1].rd_bank), 1);
    check("sim.wr_bank1", 32'(obs[1].wr_bank), 0);
    check("sim.rd_bank0", 32'(obs[0].rd_bank), 0);
    check("sim.wr_ready0", 32'(obs[0].wr_ready), 0);
    tick();
    s.rd_done = 1'b1;
    tick();
    s = '0;
    check("sim2.rd_bank0", 32'(obs[0].rd_bank), 1);
    check("sim2.wr_ready0", 32'(obs[0].wr_ready), 1);

    // Both banks full: extra write is dropped and flagged.
    do_reset();
    write_words(BDEP, 24'h020202, 1'b1);
    write_words(BDEP, 24'h000707, 1'b1);
    check("full.wr_ready0", 32'(obs[0].wr_ready), 0);
    s.wr_en   = 1'b1;
    s.wr_addr = 7'd5;
    s.wr_data = 24'hdeadbe;
    tick();
    s = '0;
    check("full.overflow0", 32'(obs[0].overflow), 1);

    // Streaming reads of 5,6,7; the RD_LAT=2 instance is timed explicitly.
    cnt        = 0;
    first      = -1;
    first_data = '0;
    for (int k = 0; k < 8; k++) begin
      s         = '0;
      s.rd_en   = (k < 3);
      s.rd_addr = AW'(5 + k);
      tick();
      if (obs[2].rd_valid) begin
        if (first < 0) begin
          first      = k;
          first_data = obs[2].rd_data;
        end
        cnt++;
      end
    end
    s = '0;
    check("lat2.count", 32'(cnt), 3);
    check("lat2.first", 32'(first), 1);
    check("lat2.data", 32'(first_data), 32'h0a0a0a);

    // Reset during a read burst from bank 1.
    s.rd_done = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      s         = '0;
      s.rd_en   = 1'b1;
      s.rd_addr = AW'(k);
      tick();
    end
    nrst = 1'b0;
    tick();
    for (int i = 0; i < ND; i++) begin
      check($sformatf("mid.rd_valid%0d", i), 32'(obs[i].rd_valid), 0);
      check($sformatf("mid.rd_data%0d", i), 32'(obs[i].rd_data), 0);
      check($sformatf("mid.rd_ready%0d", i), 32'(obs[i].rd_ready), 0);
      check($sformatf("mid.flags%0d", i), 32'({obs[i].overflow, obs[i].underrun}), 0);
    end
    nrst = 1'b1;
    s    = '0;
    tick();

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      s.wr_en   = 1'($urandom_range(0, 1));
      s.wr_addr = AW'($urandom);
      s.wr_data = DW'($urandom);
      s.wr_done = ($urandom_range(0, 39) == 0);
      s.rd_en   = 1'($urandom_range(0, 1));
      s.rd_addr = AW'($urandom);
      s.rd_done = ($urandom_range(0, 39) == 0);
      nrst      = ($urandom_range(0, 599) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
